// File: rtl/apb_ram_mw_if.sv
// APB4 bus bundle for apb_ram_mw: master drives the request, slave returns data and status.
interface apb_ram_mw_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_ram_mw.sv
// APB4 completer around a word-organised RAM with byte strobes and range/alignment errors.
// Define APB_RAM_WAIT_EN to add a WAIT_STATES stall counter in the ACCESS phase.
module apb_ram_mw #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        pclk,
    input  logic        prst,
    apb_ram_mw_if.slave bus
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned BL     = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH * STRB_W);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;

    logic [3:0]        wait_cnt;
    logic              misalign;
    logic              err_new;
    logic              latch;
    logic              commit;
    logic              pready;
    logic              pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    if (BL > 0) begin : g_align
        assign misalign = |bus.paddr[BL-1:0];
    end else begin : g_no_align
        assign misalign = 1'b0;
    end

    assign err_new = ({1'b0, bus.paddr} >= LIMIT) | misalign;
    assign latch   = (state_d == StSetup);
    // A completing cycle only commits while the master still holds psel.
    assign commit  = pready & bus.psel & write_q & ~err_q;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.psel && !bus.penable) state_d = StSetup;
            end
            StSetup: begin
                state_d = (bus.psel && bus.penable) ? StAccess : StIdle;
            end
            StAccess: begin
                if (!bus.psel) begin
                    state_d = StIdle;
                end else if (pready) begin
                    state_d = bus.penable ? StIdle : StSetup;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (state_q == StAccess && wait_cnt == 4'd0) begin
            pready  = 1'b1;
            pslverr = err_q;
            if (!write_q && !err_q) prdata = mem[idx_q];
        end
    end

    assign bus.pready  = pready;
    assign bus.pslverr = pslverr;
    assign bus.prdata  = prdata;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (latch) begin
            idx_q   <= bus.paddr[BL +: IDX_W];
            write_q <= bus.pwrite;
            err_q   <= err_new;
            wdata_q <= bus.pwdata;
            strb_q  <= bus.pstrb;
        end
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge pclk) begin
        if (commit) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

`ifdef APB_RAM_WAIT_EN
    logic [3:0] wait_cnt_q;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            wait_cnt_q <= 4'd0;
        end else if (state_q == StSetup && state_d == StAccess) begin
            wait_cnt_q <= 4'(WAIT_STATES);
        end else if (state_q == StAccess && wait_cnt_q != 4'd0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    assign wait_cnt = wait_cnt_q;
`else
    logic [3:0] unused_wait_states;

    assign unused_wait_states = 4'(WAIT_STATES);
    assign wait_cnt           = 4'd0;
`endif
endmodule

// File: tb/tb_apb_ram_mw.sv
// Directed table-driven bench for apb_ram_mw plus hand sequences for aborts, resets, chaining.
module tb_apb_ram_mw;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
`ifdef APB_RAM_WAIT_EN
    localparam int EXP_STALLS = 3;
`else
    localparam int EXP_STALLS = 0;
`endif

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic pclk;
    logic prst;
    int   n_checks;
    int   n_errors;

    apb_ram_mw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb_ram_mw #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (32),
        .WAIT_STATES(3)
    ) dut (
        .pclk(pclk),
        .prst(prst),
        .bus (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_setup(input req_t r);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = r.w;
        bus.paddr   = r.addr;
        bus.pwdata  = r.data;
        bus.pstrb   = r.strb;
    endtask

    task automatic bus_idle();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        bus.pstrb   = '0;
    endtask

    // chained: setup was already presented in the previous completing cycle.
    task automatic xfer(input req_t r, input bit chained, input bit nx_en, input req_t nx,
                        output logic [31:0] rd, output logic err, output int stalls,
                        output bit done);
        stalls = 0;
        done   = 1'b0;
        rd     = '0;
        err    = 1'b0;
        if (!chained) begin
            drive_setup(r);
            @(posedge pclk); #1;
        end
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge pclk);
            if (bus.pready) begin
                done = 1'b1;
                rd   = bus.prdata;
                err  = bus.pslverr;
                if (nx_en) drive_setup(nx);
            end else begin
                stalls++;
            end
            @(posedge pclk); #1;
        end
        if (!nx_en) bus_idle();
    endtask

    task automatic read_word(input string name, input logic [31:0] addr,
                             input logic [31:0] exp);
        req_t        r;
        logic [31:0] rd;
        logic        err;
        int          st;
        bit          ok;
        r = '{w: 1'b0, addr: addr, data: 32'h0, strb: 4'h0};
        xfer(r, 1'b0, 1'b0, r, rd, err, st, ok);
        check({name, "_done"}, 64'(ok), 64'd1);
        check({name, "_rd"}, 64'(rd), 64'(exp));
    endtask

    initial begin
        vec_t        tv [14];
        req_t        rq;
        req_t        nx;
        logic [31:0] rd;
        logic        err;
        int          st;
        bit          ok;

        n_checks = 0;
        n_errors = 0;
        tv[0]  = '{'{1'b1, 32'h04, 32'hDEADBEEF, 4'hF}, 32'h0,        1'b0};
        tv[1]  = '{'{1'b0, 32'h04, 32'h0,        4'h0}, 32'hDEADBEEF, 1'b0};
        tv[2]  = '{'{1'b1, 32'h08, 32'h11223344, 4'hF}, 32'h0,        1'b0};
        tv[3]  = '{'{1'b1, 32'h08, 32'hAABBCCDD, 4'h5}, 32'h0,        1'b0};
        tv[4]  = '{'{1'b0, 32'h08, 32'h0,        4'h0}, 32'h11BB33DD, 1'b0};
        tv[5]  = '{'{1'b1, 32'h00, 32'hCAFEF00D, 4'hF}, 32'h0,        1'b0};
        tv[6]  = '{'{1'b0, 32'h80, 32'h0,        4'h0}, 32'h0,        1'b1};
        tv[7]  = '{'{1'b1, 32'h02, 32'hFFFFFFFF, 4'hF}, 32'h0,        1'b1};
        tv[8]  = '{'{1'b0, 32'h00, 32'h0,        4'h0}, 32'hCAFEF00D, 1'b0};
        tv[9]  = '{'{1'b1, 32'h7C, 32'h5A5A1234, 4'hF}, 32'h0,        1'b0};
        tv[10] = '{'{1'b0, 32'h7C, 32'h0,        4'h0}, 32'h5A5A1234, 1'b0};
        tv[11] = '{'{1'b0, 32'h00, 32'h0,        4'h0}, 32'hCAFEF00D, 1'b0};
        tv[12] = '{'{1'b1, 32'h0C, 32'h01020304, 4'hF}, 32'h0,        1'b0};
        tv[13] = '{'{1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0}, 32'h0,        1'b0};

        bus_idle();
        prst = 1'b1;
        #12;
        check("rst_pready", 64'(bus.pready), 64'd0);
        check("rst_pslverr", 64'(bus.pslverr), 64'd0);
        check("rst_prdata", 64'(bus.prdata), 64'd0);
        @(posedge pclk); #1;
        prst = 1'b0;
        @(posedge pclk); #1;

        foreach (tv[i]) begin
            xfer(tv[i].r, 1'b0, 1'b0, tv[i].r, rd, err, st, ok);
            check($sformatf("v%0d_done", i), 64'(ok), 64'd1);
            check($sformatf("v%0d_err", i), 64'(err), 64'(tv[i].exp_err));
            check($sformatf("v%0d_rd", i), 64'(rd), 64'(tv[i].exp_rd));
            check($sformatf("v%0d_stalls", i), 64'(st), 64'(EXP_STALLS));
        end
        read_word("strb0_rd0c", 32'h0C, 32'h01020304);
        read_word("misalign_rd", 32'h7D, 32'h0);

        // Back-to-back write then read of 0x10, no IDLE in between.
        rq = '{w: 1'b1, addr: 32'h10, data: 32'h13572468, strb: 4'hF};
        nx = '{w: 1'b0, addr: 32'h10, data: 32'h0, strb: 4'h0};
        xfer(rq, 1'b0, 1'b1, nx, rd, err, st, ok);
        check("b2b_wr_done", 64'(ok), 64'd1);
        xfer(nx, 1'b1, 1'b0, nx, rd, err, st, ok);
        check("b2b_rd_done", 64'(ok), 64'd1);
        check("b2b_rd", 64'(rd), 64'h13572468);
        check("b2b_stalls", 64'(st), 64'(EXP_STALLS));

        // psel dropped during ACCESS: write must not commit.
        rq = '{w: 1'b1, addr: 32'h14, data: 32'h0BADF00D, strb: 4'hF};
        xfer(rq, 1'b0, 1'b0, rq, rd, err, st, ok);
        drive_setup('{w: 1'b1, addr: 32'h14, data: 32'hFFFFFFFF, strb: 4'hF});
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        if (EXP_STALLS > 0) begin
            @(posedge pclk); #1;
        end
        bus.psel = 1'b0;
        @(posedge pclk); #1;
        bus_idle();
        read_word("abort_access", 32'h14, 32'h0BADF00D);

        // psel dropped in SETUP: no side effect.
        drive_setup('{w: 1'b1, addr: 32'h14, data: 32'h99999999, strb: 4'hF});
        @(posedge pclk); #1;
        bus_idle();
        @(posedge pclk); #1;
        read_word("abort_setup", 32'h14, 32'h0BADF00D);

        // penable seen in IDLE must not start a transfer.
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            check($sformatf("idle_penable_%0d", c), 64'(bus.pready), 64'd0);
        end
        @(posedge pclk); #1;
        bus_idle();
        @(posedge pclk); #1;

        // Reset asserted inside ACCESS: pready drops at once, write is lost.
        drive_setup('{w: 1'b1, addr: 32'h14, data: 32'h77777777, strb: 4'hF});
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b1;
        #1;
        check("midrst_pready", 64'(bus.pready), 64'd0);
        @(posedge pclk); #1;
        bus_idle();
        prst = 1'b0;
        @(posedge pclk); #1;
        read_word("midrst_keep", 32'h14, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
